// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache refills
// and D-cache refills/writebacks, with timeout detection and per-requester done pulses.
module cache_refill_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_we,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] line_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    // Last count value seen in ISSUE before giving up: TIMEOUT waiting cycles in total.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q,  state_d;
    logic              grant_q,  grant_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              we_q,     we_d;
    logic [LINE_W-1:0] wdata_q,  wdata_d;
    logic [LINE_W-1:0] line_q,   line_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic              err_q,    err_d;

    logic              pick_dc;

    // DC wins only when it is alone or the previous grant went to IC.
    assign pick_dc = dc_req && (!ic_req || (grant_q == GNT_IC));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (ic_req || dc_req) begin
                    grant_d = pick_dc ? GNT_DC : GNT_IC;
                    if (pick_dc) begin
                        addr_d = {dc_addr[ADDR_W-1:6], 6'b0};
                        we_d   = dc_we;
                        if (dc_we) begin
                            wdata_d = dc_wdata;
                        end
                    end else begin
                        addr_d = {ic_addr[ADDR_W-1:6], 6'b0};
                        we_d   = 1'b0;
                    end
                    cnt_d   = 8'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        line_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_DC;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign line_out  = line_q;
    assign ic_done   = (state_q == ST_RESP) && (grant_q == GNT_IC);
    assign dc_done   = (state_q == ST_RESP) && (grant_q == GNT_DC);
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: refill, round-robin, writeback,
// timeout, mid-transaction reset and idle-noise scenarios.
module tb_cache_refill_arbiter;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_we;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_done;
    logic [LINE_W-1:0] line_out;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;
    logic              err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    cache_refill_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .line_out(line_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [LINE_W-1:0] pat_a5, pat_5a, pat_c3, pat_dead, ones, rd, last_line;
    logic              exp_dc;
    int                n, dn;

    initial begin
        pat_a5   = {64{8'hA5}};
        pat_5a   = {64{8'h5A}};
        pat_c3   = {64{8'hC3}};
        pat_dead = {16{32'hDEADBEEF}};
        ones     = '1;

        reset = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_addr = '0;
        dc_we = 1'b0; dc_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_line", line_out, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", {ic_done, dc_done}, 0);
        reset = 1'b0;
        tick();

        // 1: IC-only refill, ack one cycle after mem_req
        ic_addr = 64'h1234; ic_req = 1'b1;
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 64'h1200);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_no_early_done", ic_done, 0);
        mem_ack = 1'b1; mem_rdata = pat_a5;
        tick();
        chk("t1_ic_done", ic_done, 1);
        chk("t1_dc_done", dc_done, 0);
        chk("t1_line", line_out, pat_a5);
        chk("t1_req_drop", mem_req, 0);
        $display("txn ic refill addr=%0h line=%0h", mem_addr, line_out[31:0]);
        ic_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("t1_done_pulse", ic_done, 0);
        chk("t1_busy_idle", busy, 0);

        // 2: simultaneous requests straight after reset, held -> IC, DC, IC, DC
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ic_addr = 64'h1010; dc_addr = 64'h2047; dc_we = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_dc = (g % 2) == 1;
            rd = {64{8'(g + 1)}};
            tick();
            chk("t2_mem_req", mem_req, 1);
            chk("t2_mem_addr", mem_addr, exp_dc ? 64'h2040 : 64'h1000);
            mem_ack = 1'b1; mem_rdata = rd;
            tick();
            chk("t2_ic_done", ic_done, !exp_dc);
            chk("t2_dc_done", dc_done, exp_dc);
            chk("t2_line", line_out, rd);
            $display("txn rr grant=%s addr=%0h", exp_dc ? "dc" : "ic", mem_addr);
            mem_ack = 1'b0;
            if (g == 3) begin
                ic_req = 1'b0; dc_req = 1'b0;
            end
            tick();
            chk("t2_idle_gap", busy, 0);
        end
        last_line = {64{8'h04}};
        tick();
        chk("t2_no_regrant", mem_req, 0);

        // 3: DC writeback, ack after 5 waiting cycles; inputs changed mid-transaction
        dc_addr = 64'h40; dc_we = 1'b1; dc_wdata = ones; dc_req = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_mem_req", mem_req, 1);
            chk("t3_mem_we", mem_we, 1);
            chk("t3_mem_wdata", mem_wdata, ones);
            chk("t3_mem_addr", mem_addr, 64'h40);
            if (k == 2) begin
                dc_addr = 64'h9999_0000; dc_wdata = '0; dc_we = 1'b0;
            end
            tick();
        end
        chk("t3_no_done_before_ack", dc_done, 0);
        mem_ack = 1'b1; mem_rdata = pat_dead;
        tick();
        chk("t3_dc_done", dc_done, 1);
        chk("t3_line_kept", line_out, last_line);
        $display("txn dc writeback addr=40 delay=5");
        dc_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t3_done_pulse", dc_done, 0);

        // 4: timeout with no ack, then a normal transaction with err still set
        ic_addr = 64'h3000; ic_req = 1'b1;
        tick();
        chk("t4_err_before", err, 0);
        n = 0; dn = 0;
        while (mem_req && n < 300) begin
            n++;
            dn += int'(ic_done);
            tick();
        end
        chk("t4_wait_cycles", n, 255);
        chk("t4_no_done_while_waiting", dn, 0);
        chk("t4_ic_done", ic_done, 1);
        chk("t4_err", err, 1);
        chk("t4_line_kept", line_out, last_line);
        $display("txn ic timeout wait=%0d err=%0b", n, err);
        ic_req = 1'b0;
        tick();
        chk("t4_busy_idle", busy, 0);
        chk("t4_done_once", ic_done, 0);
        dc_addr = 64'h80; dc_we = 1'b0; dc_req = 1'b1;
        tick();
        chk("t4_next_addr", mem_addr, 64'h80);
        mem_ack = 1'b1; mem_rdata = pat_5a;
        tick();
        chk("t4_next_done", dc_done, 1);
        chk("t4_next_line", line_out, pat_5a);
        chk("t4_err_sticky", err, 1);
        $display("txn dc refill after timeout addr=80");
        dc_req = 1'b0; mem_ack = 1'b0;
        tick();

        // 5: reset asserted during ISSUE
        ic_addr = 64'h4000; ic_req = 1'b1;
        tick();
        chk("t5_issue", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_err", err, 0);
        mem_ack = 1'b1;
        tick();
        chk("t5_no_done", {ic_done, dc_done}, 0);
        reset = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t5_regrant", mem_req, 1);
        chk("t5_addr", mem_addr, 64'h4000);
        mem_ack = 1'b1; mem_rdata = pat_c3;
        tick();
        chk("t5_done", ic_done, 1);
        chk("t5_line", line_out, pat_c3);
        chk("t5_err_clear", err, 0);
        $display("txn ic refill after reset addr=4000");
        ic_req = 1'b0; mem_ack = 1'b0;
        tick();

        // 6: idle noise on dc_addr and mem_ack
        for (int k = 0; k < 6; k++) begin
            dc_addr = 64'(k) * 64'h1111_0000;
            mem_ack = (k % 2) == 1;
            mem_rdata = pat_dead;
            tick();
            chk("t6_busy", busy, 0);
            chk("t6_mem_req", mem_req, 0);
            chk("t6_mem_addr", mem_addr, 64'h4000);
            chk("t6_line", line_out, pat_c3);
            chk("t6_done", {ic_done, dc_done}, 0);
        end
        mem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
